// File: rtl/rr_quantum_timer_pkg.sv
// Shared constants for the round-robin quantum timer: FSM state encoding,
// control-stage opcodes and the default slice length.
package rr_quantum_timer_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    // Opcodes of the upstream environment/control-variables stage that drive atv_temp/block.
    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_DISPATCH = 4'h1;
    localparam logic [3:0] OP_RR       = 4'h2;
    localparam logic [3:0] OP_INPUT    = 4'h3;
    localparam logic [3:0] OP_KSWAP    = 4'h4;

    localparam int QUANTUM_DEF = 1000;

endpackage

// File: rtl/rr_sat_counter8.sv
// 8-bit event counter that sticks at 255; used to count slice expiries.
module rr_sat_counter8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_inc,
    output logic [7:0] o_count
);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (i_inc && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/rr_quantum_timer.sv
// Round-robin time-slice timer: counts the running process's quantum and holds
// so_kernel until reset_rr. Optional programmable quantum under RR_QUANTUM_PROG_EN.
//
// state   | meaning
// IDLE    | no slice armed, waiting for atv_temp
// RUN     | slice counting down one per cycle
// HOLD    | slice frozen while an input op is in progress
// EXPIRED | slice used up, so_kernel held until reset_rr
module rr_quantum_timer
    import rr_quantum_timer_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int QUANTUM = QUANTUM_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reset_rr,
    input  logic             atv_temp,
    input  logic             block,
`ifdef RR_QUANTUM_PROG_EN
    input  logic             q_we,
    input  logic [CNT_W-1:0] q_in,
`endif
    output logic             so_kernel,
    output logic             busy,
    output logic [CNT_W-1:0] time_left,
    output logic [7:0]       preempt_cnt
);

    localparam logic [CNT_W-1:0] Q_CONST = CNT_W'(QUANTUM);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_time_left;
    logic             r_so_kernel;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_time_left_nxt;
    logic             w_expire;
    logic [CNT_W-1:0] w_quantum;
    logic [CNT_W-1:0] w_dec;
    logic             w_at_one;
    logic             w_can_dec;

`ifdef RR_QUANTUM_PROG_EN
    logic [CNT_W-1:0] r_quantum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_quantum <= Q_CONST;
        end else if (q_we && (q_in != '0)) begin
            r_quantum <= q_in;
        end
    end

    assign w_quantum = r_quantum;
`else
    assign w_quantum = Q_CONST;
`endif

    assign w_dec     = r_time_left - CNT_W'(1);
    assign w_at_one  = (r_time_left == CNT_W'(1));
    assign w_can_dec = (r_time_left != '0);

    // Leaving HOLD consumes the resuming edge as a count, so an N-cycle block adds exactly N cycles.
    always_comb begin
        w_state_nxt     = r_state;
        w_time_left_nxt = r_time_left;
        w_expire        = 1'b0;
        if (reset_rr) begin
            w_state_nxt     = ST_IDLE;
            w_time_left_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (atv_temp) begin
                        w_time_left_nxt = w_quantum;
                        w_state_nxt     = block ? ST_HOLD : ST_RUN;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    if (atv_temp) begin
                        w_time_left_nxt = w_quantum;
                        if (r_state == ST_HOLD) begin
                            w_state_nxt = block ? ST_HOLD : ST_RUN;
                        end
                    end else if (block) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_RUN;
                        if (w_can_dec) begin
                            w_time_left_nxt = w_dec;
                            if (w_at_one) begin
                                w_state_nxt = ST_EXPIRED;
                                w_expire    = 1'b1;
                            end
                        end
                    end
                end
                ST_EXPIRED: begin
                    w_time_left_nxt = '0;
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_time_left_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_time_left <= '0;
            r_so_kernel <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_time_left <= w_time_left_nxt;
            r_so_kernel <= (w_state_nxt == ST_EXPIRED);
            r_busy      <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HOLD);
        end
    end

    rr_sat_counter8 u_preempt_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_expire),
        .o_count (preempt_cnt)
    );

    assign so_kernel = r_so_kernel;
    assign busy      = r_busy;
    assign time_left = r_time_left;

endmodule

// File: tb/tb_rr_quantum_timer.sv
// Bench for rr_quantum_timer: QUANTUM=5 and QUANTUM=1 instances, vector table plus
// hand sequences; RR_QUANTUM_PROG_EN adds the programmable-quantum sequence.
module tb_rr_quantum_timer;

    typedef struct {
        logic        sel;
        logic        rst;
        logic        rr;
        logic        atv;
        logic        blk;
        logic        sk;
        logic        busy;
        logic [15:0] tl;
        logic [7:0]  pc;
    } vec_t;

    typedef struct {
        int          id;
        logic        sel;
        logic        sk;
        logic        busy;
        logic [15:0] tl;
        logic [7:0]  pc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst5 = 1'b0, rr5 = 1'b0, atv5 = 1'b0, blk5 = 1'b0;
    logic rst1 = 1'b0, rr1 = 1'b0, atv1 = 1'b0, blk1 = 1'b0;
    logic sk5, busy5, sk1, busy1;
    logic [15:0] tl5, tl1;
    logic [7:0]  pc5, pc1;
`ifdef RR_QUANTUM_PROG_EN
    logic        qwe5 = 1'b0, qwe1 = 1'b0;
    logic [15:0] qin5 = 16'd0, qin1 = 16'd0;
`endif

    rr_quantum_timer #(.CNT_W(16), .QUANTUM(5)) u_dut5 (
        .clk         (clk),
        .reset       (rst5),
        .reset_rr    (rr5),
        .atv_temp    (atv5),
        .block       (blk5),
`ifdef RR_QUANTUM_PROG_EN
        .q_we        (qwe5),
        .q_in        (qin5),
`endif
        .so_kernel   (sk5),
        .busy        (busy5),
        .time_left   (tl5),
        .preempt_cnt (pc5)
    );

    rr_quantum_timer #(.CNT_W(16), .QUANTUM(1)) u_dut1 (
        .clk         (clk),
        .reset       (rst1),
        .reset_rr    (rr1),
        .atv_temp    (atv1),
        .block       (blk1),
`ifdef RR_QUANTUM_PROG_EN
        .q_we        (qwe1),
        .q_in        (qin1),
`endif
        .so_kernel   (sk1),
        .busy        (busy1),
        .time_left   (tl1),
        .preempt_cnt (pc1)
    );

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic sel, rst, rr, atv, blk, sk, busy,
                                input int tl, input int pc);
        vec_t v;
        v.sel = sel; v.rst = rst; v.rr = rr; v.atv = atv; v.blk = blk;
        v.sk = sk; v.busy = busy; v.tl = 16'(tl); v.pc = 8'(pc);
        return v;
    endfunction

    task automatic add(input logic sel, rst, rr, atv, blk, sk, busy,
                       input int tl, input int pc);
        vecs.push_back(mk(sel, rst, rr, atv, blk, sk, busy, tl, pc));
    endtask

    task automatic step(input vec_t v, input int id);
        exp_t e;
        exp_t g;
        logic        a_sk, a_busy;
        logic [15:0] a_tl;
        logic [7:0]  a_pc;
        @(negedge clk);
        rst5 = v.sel ? 1'b0 : v.rst;  rr5 = v.sel ? 1'b0 : v.rr;
        atv5 = v.sel ? 1'b0 : v.atv;  blk5 = v.sel ? 1'b0 : v.blk;
        rst1 = v.sel ? v.rst : 1'b0;  rr1 = v.sel ? v.rr : 1'b0;
        atv1 = v.sel ? v.atv : 1'b0;  blk1 = v.sel ? v.blk : 1'b0;
        e.id = id; e.sel = v.sel; e.sk = v.sk; e.busy = v.busy; e.tl = v.tl; e.pc = v.pc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL vec %0d: scoreboard empty, no expected entry", id);
        end else begin
            g = sb.pop_front();
            a_sk   = g.sel ? sk1   : sk5;
            a_busy = g.sel ? busy1 : busy5;
            a_tl   = g.sel ? tl1   : tl5;
            a_pc   = g.sel ? pc1   : pc5;
            if (a_sk !== g.sk || a_busy !== g.busy || a_tl !== g.tl || a_pc !== g.pc) begin
                n_bad++;
                $display("FAIL vec %0d (dut Q=%0d): got sk=%0b busy=%0b tl=%0d pc=%0d, want sk=%0b busy=%0b tl=%0d pc=%0d",
                         g.id, g.sel ? 1 : 5, a_sk, a_busy, a_tl, a_pc, g.sk, g.busy, g.tl, g.pc);
            end
        end
    endtask

    initial begin
        int pc;
        int id;

        // reset both instances, then basic slice with QUANTUM=5
        add(0,1,0,0,0, 0,0,0,0);
        add(1,1,0,0,0, 0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0);
        add(0,0,0,0,1, 0,0,0,0);
        add(0,0,0,1,0, 0,1,5,0);
        for (int t = 4; t >= 1; t--) add(0,0,0,0,0, 0,1,t,0);
        add(0,0,0,0,0, 1,0,0,1);
        for (int i = 0; i < 10; i++) add(0,0,0,logic'(i % 2), logic'(i % 3 == 0), 1,0,0,1);
        add(0,0,1,0,0, 0,0,0,1);
        // block for 3 cycles after the 2nd decrement: expiry 8 edges after arm
        add(0,0,0,1,0, 0,1,5,1);
        add(0,0,0,0,0, 0,1,4,1);
        add(0,0,0,0,0, 0,1,3,1);
        for (int i = 0; i < 3; i++) add(0,0,0,0,1, 0,1,3,1);
        add(0,0,0,0,0, 0,1,2,1);
        add(0,0,0,0,0, 0,1,1,1);
        add(0,0,0,0,0, 1,0,0,2);
        add(0,0,1,0,0, 0,0,0,2);
        // re-arm at time_left=2
        add(0,0,0,1,0, 0,1,5,2);
        for (int t = 4; t >= 2; t--) add(0,0,0,0,0, 0,1,t,2);
        add(0,0,0,1,0, 0,1,5,2);
        for (int t = 4; t >= 1; t--) add(0,0,0,0,0, 0,1,t,2);
        add(0,0,0,0,0, 1,0,0,3);
        add(0,0,1,0,0, 0,0,0,3);
        // reset_rr together with atv_temp: lands in IDLE, no reload
        add(0,0,0,1,0, 0,1,5,3);
        add(0,0,0,0,0, 0,1,4,3);
        add(0,0,1,1,0, 0,0,0,3);
        add(0,0,0,0,0, 0,0,0,3);
        // HOLD entry/exit and reload paths
        add(0,0,0,1,1, 0,1,5,3);
        add(0,0,0,0,1, 0,1,5,3);
        add(0,0,0,0,0, 0,1,4,3);
        add(0,0,0,0,0, 0,1,3,3);
        add(0,0,0,0,1, 0,1,3,3);
        add(0,0,0,1,1, 0,1,5,3);
        add(0,0,0,1,0, 0,1,5,3);
        add(0,0,0,0,0, 0,1,4,3);
        add(0,0,0,1,1, 0,1,5,3);
        add(0,0,0,0,0, 0,1,4,3);
        // mid-run global reset clears everything
        add(0,1,0,0,0, 0,0,0,0);
        // blocked at time_left=1, release expires on that edge
        add(0,0,0,1,0, 0,1,5,0);
        for (int t = 4; t >= 1; t--) add(0,0,0,0,0, 0,1,t,0);
        add(0,0,0,0,1, 0,1,1,0);
        add(0,0,0,0,0, 1,0,0,1);
        add(0,0,1,0,0, 0,0,0,1);
        // QUANTUM=1: expiry on the very next edge
        add(1,0,0,1,0, 0,1,1,0);
        add(1,0,0,0,0, 1,0,0,1);
        add(1,0,1,0,0, 0,0,0,1);

        foreach (vecs[i]) step(vecs[i], i);

        // saturation of preempt_cnt on the QUANTUM=1 instance
        id = 1000;
        pc = 1;
        for (int i = 0; i < 300; i++) begin
            step(mk(1,0,0,1,0, 0,1,1,pc), id++);
            pc = (pc < 255) ? pc + 1 : 255;
            step(mk(1,0,0,0,0, 1,0,0,pc), id++);
            step(mk(1,0,1,0,0, 0,0,0,pc), id++);
        end
        step(mk(1,0,0,1,0, 0,1,1,255), id++);
        step(mk(1,1,0,0,0, 0,0,0,0), id++);

`ifdef RR_QUANTUM_PROG_EN
        // write during a slice only affects the next load; q_in=0 is ignored
        id = 5000;
        step(mk(0,0,0,1,0, 0,1,5,1), id++);
        qwe5 = 1'b1; qin5 = 16'd3;
        step(mk(0,0,0,0,0, 0,1,4,1), id++);
        qwe5 = 1'b0;
        for (int t = 3; t >= 1; t--) step(mk(0,0,0,0,0, 0,1,t,1), id++);
        step(mk(0,0,0,0,0, 1,0,0,2), id++);
        step(mk(0,0,1,0,0, 0,0,0,2), id++);
        step(mk(0,0,0,1,0, 0,1,3,2), id++);
        step(mk(0,0,0,0,0, 0,1,2,2), id++);
        step(mk(0,0,0,0,0, 0,1,1,2), id++);
        step(mk(0,0,0,0,0, 1,0,0,3), id++);
        step(mk(0,0,1,0,0, 0,0,0,3), id++);
        qwe5 = 1'b1; qin5 = 16'd0;
        step(mk(0,0,0,0,0, 0,0,0,3), id++);
        qwe5 = 1'b0;
        step(mk(0,0,0,1,0, 0,1,3,3), id++);
        step(mk(0,0,1,0,0, 0,0,0,3), id++);
`endif

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: got %0d leftover entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_quantum_timer.md
Name: rr_quantum_timer

Overview:
- Round-robin time-slice timer directly downstream of the environment/control-variables stage.
- Consumes that stage's slice-arm, kernel-swap restart and input-block strobes.
- Counts the current process's quantum and raises a kernel-entry request (so_kernel) when the slice expires.
- The request is held until the kernel acknowledges it by restarting the timer.

Parameters:
- CNT_W, 16: width of the slice counter and of time_left.
- QUANTUM, 1000: slice length in unblocked clock cycles. Legal range 1 .. 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high global reset.
- reset_rr  in  1  kernel-swap restart; acknowledges expiry and returns the block to idle.
- atv_temp  in  1  arm/reload request (process dispatch or round-robin op).
- block  in  1  pause request (input op in progress); freezes the count.
- so_kernel  out  1  slice expired; request kernel mode. Level, held.
- busy  out  1  high in RUN or HOLD.
- time_left  out  CNT_W  remaining cycles of the current slice.
- preempt_cnt  out  8  number of expiries since reset. Saturating.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on port reset.
- All outputs are registered.
- Reset values: so_kernel=0, busy=0, time_left=0, preempt_cnt=0, state=IDLE.
- Per-edge priority: reset > reset_rr > atv_temp > block > decrement.
- IDLE:
  - atv_temp=1 with block=0 -> RUN, time_left<=QUANTUM.
  - atv_temp=1 with block=1 -> HOLD, time_left<=QUANTUM.
  - Otherwise stay in IDLE.
- RUN:
  - atv_temp=1 -> reload time_left<=QUANTUM and stay in RUN (new slice).
  - Else block=1 -> HOLD, time_left unchanged.
  - Else time_left<=time_left-1.
  - If time_left==1 at that edge -> EXPIRED, so_kernel<=1, preempt_cnt+=1 (saturates at 255).
- HOLD:
  - atv_temp=1 -> reload QUANTUM, stay in HOLD if block=1, else go to RUN.
  - block=0 -> RUN with no reload; counting resumes on the following edge.
- EXPIRED:
  - so_kernel=1 and time_left=0 are held.
  - atv_temp and block are ignored.
  - Only reset_rr or reset leaves this state.
- reset_rr in any state -> IDLE, time_left<=0, so_kernel<=0. preempt_cnt is kept.
- Latency: with block low throughout, so_kernel rises exactly QUANTUM edges after the edge that sampled atv_temp. With QUANTUM=1, it rises on the next edge.
- Simultaneous reset_rr and atv_temp: reset_rr wins and the block lands in IDLE. atv_temp must be re-presented.
- A block pulse of N cycles in RUN extends the expiry by exactly N cycles.
- time_left never wraps below 0. Decrement is only performed when time_left>=1.

Optional Feature:
- Macro: RR_QUANTUM_PROG_EN.
- When defined:
  - Adds ports q_we (in, 1) and q_in (in, CNT_W).
  - Internal quantum_reg resets to QUANTUM.
  - On q_we=1 with q_in!=0, quantum_reg<=q_in. q_in==0 is ignored.
  - All reloads use quantum_reg. A write during RUN does not alter the current slice; it takes effect at the next load.
- When undefined: no extra ports; reloads use the constant QUANTUM.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE, RUN, HOLD, EXPIRED (2 bits).
  - The opcode constants shared with the control stage.
  - The default QUANTUM value.
- One natural sub-module: rr_sat_counter8, an 8-bit saturating event counter used for preempt_cnt.
- The FSM and slice counter stay in the top module.

Test Plan:
- Reset then atv_temp pulse, QUANTUM=5 -> busy=1, time_left=5,4,3,2,1,0. so_kernel=1 exactly 5 edges after the arm edge. preempt_cnt=1.
- Expired, then 10 idle cycles, then reset_rr -> so_kernel held at 1 for all 10 cycles. After reset_rr: IDLE, so_kernel=0, time_left=0, preempt_cnt still 1.
- QUANTUM=5, block high for 3 cycles after the 2nd decrement -> time_left frozen at 3. Expiry delayed by exactly 3 cycles (8 edges total).
- atv_temp re-pulsed at time_left=2 -> time_left reloads to 5; expiry 5 edges later. Same edge with reset_rr -> IDLE, no reload.
- 300 consecutive expire/reset_rr cycles with QUANTUM=1 -> preempt_cnt saturates at 255. A mid-run reset clears all outputs to 0.
- RR_QUANTUM_PROG_EN: q_we with q_in=3 during a 5-cycle slice -> current slice still expires at 5. Next slice expires at 3. q_in=0 write is ignored.
